imem_responder: RTL and testbench

IMEM_RESPONDER -- requirements
Module: imem_responder

---
 rtl/imem_responder.sv | 184 ++++++++++++++++++
 tb/tb_imem_responder.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// Instruction-fetch responder: accepts one fetch at a time, reads one or two
// words from a synchronous backing memory and returns a 32-bit instruction.
module imem_responder #(
    parameter int MEM_WORDS   = 4096,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic [31:0] addr_i,
    input  logic        flush_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        mem_req_o,
    output logic [29:0] mem_addr_o,
    input  logic [31:0] mem_rdata_i
);

    localparam logic [31:0] MEM_LIMIT = 32'(MEM_WORDS);
    localparam bit          HAS_WAIT  = (WAIT_CYCLES > 0);
    localparam logic [3:0]  WAIT_INIT = HAS_WAIT ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RD_LO,
        ST_RD_HI
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        phase_q, phase_d;
    logic [15:0] hold_q, hold_d;
    logic        rvalid_q, rvalid_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

    logic [31:0] idx_lo_ext;
    logic [31:0] idx_hi_ext;
    logic        lo_oob;
    logic        hi_oob;
    logic        fault;
    logic        deliver;
    logic [31:0] dword;

    // Range checks use the unwrapped sum so index 2^30-1 plus one faults.
    assign idx_lo_ext = {2'b00, addr_q[31:2]};
    assign idx_hi_ext = idx_lo_ext + 32'd1;
    assign lo_oob     = (idx_lo_ext >= MEM_LIMIT);
    assign hi_oob     = (idx_hi_ext >= MEM_LIMIT);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        phase_d    = phase_q;
        hold_d     = hold_q;
        rvalid_d   = 1'b0;
        err_d      = err_q;
        rdata_d    = rdata_q;
        gnt_o      = 1'b0;
        mem_req_o  = 1'b0;
        mem_addr_o = '0;
        fault      = 1'b0;
        deliver    = 1'b0;
        dword      = '0;

        case (state_q)
            ST_IDLE: begin
                gnt_o = !flush_i;
                if (req_i && !flush_i) begin
                    addr_d = addr_i;
                    if (HAS_WAIT) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_INIT;
                    end else if (addr_i[0]) begin
                        fault = 1'b1;
                    end else begin
                        state_d = ST_RD_LO;
                        phase_d = 1'b0;
                    end
                end
            end
            ST_WAIT: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == 4'd0) begin
                    if (addr_q[0]) begin
                        fault = 1'b1;
                    end else begin
                        state_d = ST_RD_LO;
                        phase_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RD_LO: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else if (!phase_q) begin
                    mem_req_o  = !lo_oob;
                    mem_addr_o = addr_q[31:2];
                    phase_d    = 1'b1;
                end else if (lo_oob) begin
                    fault = 1'b1;
                end else if (!addr_q[1]) begin
                    deliver = 1'b1;
                    dword   = mem_rdata_i;
                end else if (mem_rdata_i[17:16] != 2'b11) begin
                    deliver = 1'b1;
                    dword   = {16'h0000, mem_rdata_i[31:16]};
                end else begin
                    // Upper parcel is a 32-bit instruction: fetch the next word
                    // back-to-back while holding the first half.
                    hold_d     = mem_rdata_i[31:16];
                    mem_req_o  = !hi_oob;
                    mem_addr_o = idx_hi_ext[29:0];
                    state_d    = ST_RD_HI;
                end
            end
            ST_RD_HI: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else if (hi_oob) begin
                    fault = 1'b1;
                end else begin
                    deliver = 1'b1;
                    dword   = {mem_rdata_i[15:0], hold_q};
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (fault) begin
            rvalid_d = 1'b1;
            err_d    = 1'b1;
            rdata_d  = '0;
            state_d  = ST_IDLE;
        end
        if (deliver) begin
            rvalid_d = 1'b1;
            err_d    = 1'b0;
            rdata_d  = dword;
            state_d  = ST_IDLE;
        end

        if (rst_i) begin
            gnt_o      = 1'b0;
            mem_req_o  = 1'b0;
            mem_addr_o = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            phase_q  <= 1'b0;
            hold_q   <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            phase_q  <= phase_d;
            hold_q   <= hold_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    assign rvalid_o = rvalid_q;
    assign err_o    = err_q;
    assign rdata_o  = rdata_q;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: a zero-wait instance with a 256-word
// memory for the vector table, and a three-wait-state instance for timing.
module tb_imem_responder;

    localparam int MW = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0;
    logic        req3 = 1'b0;
    logic [31:0] addr = '0;
    logic        flush = 1'b0;

    logic        gnt0, rvalid0, err0, mreq0;
    logic [31:0] rdata0, mrd0;
    logic [29:0] maddr0;
    logic        gnt3, rvalid3, err3, mreq3;
    logic [31:0] rdata3, mrd3;
    logic [29:0] maddr3;

    logic [31:0] mem [0:MW-1];
    int          oob_reads = 0;

    int checks = 0;
    int errors = 0;
    logic sel = 1'b0;

    imem_responder #(.MEM_WORDS(MW), .WAIT_CYCLES(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .req_i(req0), .addr_i(addr), .flush_i(flush),
        .gnt_o(gnt0), .rvalid_o(rvalid0), .rdata_o(rdata0), .err_o(err0),
        .mem_req_o(mreq0), .mem_addr_o(maddr0), .mem_rdata_i(mrd0)
    );

    imem_responder #(.MEM_WORDS(MW), .WAIT_CYCLES(3)) dut3 (
        .clk_i(clk), .rst_i(rst), .req_i(req3), .addr_i(addr), .flush_i(flush),
        .gnt_o(gnt3), .rvalid_o(rvalid3), .rdata_o(rdata3), .err_o(err3),
        .mem_req_o(mreq3), .mem_addr_o(maddr3), .mem_rdata_i(mrd3)
    );

    always #5 clk = ~clk;

    // Synchronous memory: data one cycle after the strobe; reads past the end are counted.
    always @(posedge clk) begin
        if (mreq0) begin
            if (maddr0 < 30'(MW)) mrd0 <= mem[maddr0[7:0]];
            else begin mrd0 <= 32'hDEADBEEF; oob_reads <= oob_reads + 1; end
        end
        if (mreq3) begin
            if (maddr3 < 30'(MW)) mrd3 <= mem[maddr3[7:0]];
            else begin mrd3 <= 32'hDEADBEEF; oob_reads <= oob_reads + 1; end
        end
    end

    logic        gnt_s, rv_s, er_s, mreq_s;
    logic [31:0] rd_s;
    logic [29:0] ma_s;
    assign gnt_s  = sel ? gnt3    : gnt0;
    assign rv_s   = sel ? rvalid3 : rvalid0;
    assign er_s   = sel ? err3    : err0;
    assign mreq_s = sel ? mreq3   : mreq0;
    assign rd_s   = sel ? rdata3  : rdata0;
    assign ma_s   = sel ? maddr3  : maddr0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] rd;
        logic        err;
        int          lat;
        int          nrd;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] w0, input logic [31:0] w1);
        int unsigned i;
        i = a >> 2;
        if (i < MW) mem[i] = w0;
        if (i + 1 < MW) mem[i + 1] = w1;
    endtask

    task automatic do_fetch(input logic [31:0] a, output int lat, output int nrd,
                            output int first_k, output logic [29:0] idx0,
                            output logic [29:0] idx1, output logic [31:0] rd,
                            output logic er, output logic g_rv, output logic g_acc);
        @(posedge clk); #1;
        addr = a;
        if (sel) req3 = 1'b1; else req0 = 1'b1;
        @(negedge clk);
        g_acc = gnt_s;
        @(posedge clk); #1;
        req0 = 1'b0; req3 = 1'b0;
        lat = 0; nrd = 0; first_k = 0; idx0 = '0; idx1 = '0;
        rd = '0; er = 1'b0; g_rv = 1'b0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(negedge clk);
            if (mreq_s) begin
                if (nrd == 0) begin idx0 = ma_s; first_k = k; end
                else idx1 = ma_s;
                nrd++;
            end
            if (rv_s) begin
                lat = k; rd = rd_s; er = er_s; g_rv = gnt_s;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, nrd, fk, cnt;
        logic [29:0] i0, i1;
        logic [31:0] rd;
        logic er, grv, gacc;

        for (int i = 0; i < MW; i++) mem[i] = '0;

        vecs[0]  = '{32'h0000_0100, 32'h00A0_0093, 32'h0000_0000, 32'h00A0_0093, 1'b0, 3, 1};
        vecs[1]  = '{32'h0000_0102, 32'h4505_0093, 32'h0000_0000, 32'h0000_4505, 1'b0, 3, 1};
        vecs[2]  = '{32'h0000_0102, 32'h0093_1234, 32'h5678_00A0, 32'h00A0_0093, 1'b0, 4, 2};
        vecs[3]  = '{32'h0000_0101, 32'h1111_1111, 32'h0000_0000, 32'h0000_0000, 1'b1, 1, 0};
        vecs[4]  = '{32'h0000_0103, 32'h1111_1111, 32'h0000_0000, 32'h0000_0000, 1'b1, 1, 0};
        vecs[5]  = '{32'h0000_03FE, 32'h0003_1111, 32'h0000_0000, 32'h0000_0000, 1'b1, 4, 1};
        vecs[6]  = '{32'h0000_03FE, 32'h0001_2222, 32'h0000_0000, 32'h0000_0001, 1'b0, 3, 1};
        vecs[7]  = '{32'h0000_0400, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 3, 0};
        vecs[8]  = '{32'hFFFF_FFFE, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 3, 0};
        vecs[9]  = '{32'h0000_03FC, 32'hCAFE_F00D, 32'h0003_1111, 32'hCAFE_F00D, 1'b0, 3, 1};
        vecs[10] = '{32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 1'b0, 3, 1};
        vecs[11] = '{32'h0000_0002, 32'hABCD_0000, 32'h0000_0000, 32'h0000_ABCD, 1'b0, 3, 1};

        // Reset state, with a request held high to show it is not granted.
        req0 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt",    {31'b0, gnt0},    32'd0);
        chk("rst_rvalid", {31'b0, rvalid0}, 32'd0);
        chk("rst_err",    {31'b0, err0},    32'd0);
        chk("rst_rdata",  rdata0,           32'd0);
        chk("rst_memreq", {31'b0, mreq0},   32'd0);
        chk("rst_memaddr", {2'b0, maddr0},  32'd0);
        @(posedge clk); #1;
        req0 = 1'b0; rst = 1'b0;
        @(negedge clk);
        chk("gnt_after_rst", {31'b0, gnt0}, 32'd1);

        sel = 1'b0;
        for (int v = 0; v < 12; v++) begin
            load(vecs[v].addr, vecs[v].w0, vecs[v].w1);
            do_fetch(vecs[v].addr, lat, nrd, fk, i0, i1, rd, er, grv, gacc);
            chk($sformatf("v%0d_gnt", v),     {31'b0, gacc}, 32'd1);
            chk($sformatf("v%0d_lat", v),     32'(lat), 32'(vecs[v].lat));
            chk($sformatf("v%0d_reads", v),   32'(nrd), 32'(vecs[v].nrd));
            chk($sformatf("v%0d_rdata", v),   rd, vecs[v].rd);
            chk($sformatf("v%0d_err", v),     {31'b0, er}, {31'b0, vecs[v].err});
            chk($sformatf("v%0d_gnt_rv", v),  {31'b0, grv}, 32'd1);
            if (vecs[v].nrd > 0) begin
                chk($sformatf("v%0d_idx0", v), {2'b0, i0}, vecs[v].addr >> 2);
                chk($sformatf("v%0d_first", v), 32'(fk), 32'd1);
            end
            if (vecs[v].nrd > 1)
                chk($sformatf("v%0d_idx1", v), {2'b0, i1}, (vecs[v].addr >> 2) + 1);
        end

        // Reset one cycle into an aligned fetch discards it and clears outputs.
        @(posedge clk); #1;
        addr = 32'h0000_0100; req0 = 1'b1;
        @(posedge clk); #1;
        req0 = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("rstmid_memreq", {31'b0, mreq0}, 32'd0);
        chk("rstmid_gnt",    {31'b0, gnt0},  32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_gnt_after", {31'b0, gnt0}, 32'd1);
        chk("rstmid_rdata",     rdata0,        32'd0);
        chk("rstmid_err",       {31'b0, err0}, 32'd0);
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rvalid0 || mreq0) cnt++;
        end
        chk("rstmid_quiet", 32'(cnt), 32'd0);

        // Flush in the issue cycle suppresses the read and the response.
        @(posedge clk); #1;
        addr = 32'h0000_0100; req0 = 1'b1;
        @(posedge clk); #1;
        req0 = 1'b0; flush = 1'b1;
        @(negedge clk);
        chk("flush_rd_memreq", {31'b0, mreq0}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_rd_gnt", {31'b0, gnt0}, 32'd1);
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (rvalid0 || mreq0) cnt++;
        end
        chk("flush_rd_quiet", 32'(cnt), 32'd0);

        // Flush together with a request in IDLE: not granted, nothing issued.
        @(posedge clk); #1;
        req0 = 1'b1; flush = 1'b1;
        @(negedge clk);
        chk("flush_req_gnt", {31'b0, gnt0}, 32'd0);
        @(posedge clk); #1;
        req0 = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("flush_req_memreq", {31'b0, mreq0}, 32'd0);

        // Flush in the response cycle: pulse still shown, then outputs hold.
        load(32'h0000_0100, 32'h00A0_0093, 32'h0);
        @(posedge clk); #1;
        addr = 32'h0000_0100; req0 = 1'b1;
        @(posedge clk); #1;
        req0 = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_rv_pulse", {31'b0, rvalid0}, 32'd1);
        chk("flush_rv_rdata", rdata0, 32'h00A0_0093);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("hold_rvalid", {31'b0, rvalid0}, 32'd0);
        chk("hold_rdata",  rdata0, 32'h00A0_0093);

        // err_o holds after a fault response.
        do_fetch(32'h0000_0101, lat, nrd, fk, i0, i1, rd, er, grv, gacc);
        chk("fault_lat", 32'(lat), 32'd1);
        @(negedge clk);
        chk("hold_err",    {31'b0, err0},    32'd1);
        chk("hold_rv_err", {31'b0, rvalid0}, 32'd0);

        // Three wait states.
        sel = 1'b1;
        load(32'h0000_0000, 32'h1234_5678, 32'h0);
        do_fetch(32'h0000_0000, lat, nrd, fk, i0, i1, rd, er, grv, gacc);
        chk("w3_first_req", 32'(fk),  32'd4);
        chk("w3_lat",       32'(lat), 32'd6);
        chk("w3_rdata",     rd,       32'h1234_5678);
        chk("w3_reads",     32'(nrd), 32'd1);
        do_fetch(32'h0000_0101, lat, nrd, fk, i0, i1, rd, er, grv, gacc);
        chk("w3_mis_lat",   32'(lat), 32'd4);
        chk("w3_mis_err",   {31'b0, er}, 32'd1);
        chk("w3_mis_reads", 32'(nrd), 32'd0);

        // Flush during wait states at T+2.
        @(posedge clk); #1;
        addr = 32'h0000_0000; req3 = 1'b1;
        @(negedge clk);
        chk("w3fl_gnt_acc", {31'b0, gnt3}, 32'd1);
        @(posedge clk); #1;
        req3 = 1'b0;
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        chk("w3fl_gnt_flush", {31'b0, gnt3}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("w3fl_gnt_t3", {31'b0, gnt3}, 32'd1);
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (rvalid3 || mreq3) cnt++;
        end
        chk("w3fl_quiet", 32'(cnt), 32'd0);

        chk("oob_reads", 32'(oob_reads), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
